rx_deframer: RTL and testbench
==============================

Name: rx_deframer

Overview:
- HDLC-style bit-level receiver; it is the receive-side counterpart of the transmit framer.
- Hunts for 0x7E flags, removes stuffed zeros, detects aborts, and assembles LSB-first octets.
- Presents each octet plus frame status to the SPI side as one 16-bit word, through a single holding register with request/strobe handshake.
- Sits between the line receiver (bit stream plus bit-enable) and the SPI slave.

Parameters:
- None. The word format is fixed at 16 bits and octets at 8 bits.

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
rxdata  input  1  received line bit, sampled only when bit_en=1
bit_en  input  1  one-clk pulse per received bit
enable  input  1  0 forces HUNT and clears the window mask
spi_data  output  16  holding register: [15] eop, [14] byte valid, [13] abort, [12] residue error, [11:8] 0, [7:0] octet
spi_data_request  output  1  holding register full
spi_data_strobe  input  1  consumer read; only a rising edge counts
overrun  output  1  sticky; set when a word is produced while the holding register is full
rx_active  output  1  high while in FRAME

Behaviour:
- Reset values: spi_data=0, spi_data_request=0, overrun=0, rx_active=0, state=HUNT, window w=0, mask=0, ones count=0, bit count=0, pending byte empty, strobe edge register=0.
- Raw window: on bit_en, w <= {w[6:0], rxdata}; w[0] is the newest bit. All other pipeline steps below also act only on bit_en cycles.
- Flag event: the new w equals 0x7E.
- Abort event: the new w[6:0] equals 0x7F (seven consecutive ones).
- Mask: on a flag or abort event, mask <= 0. Otherwise mask <= {mask[6:0], 1}.
- Delayed data bit: the bit leaving w (old w[7]) is emitted to destuff logic only if the old mask[7]=1 and state is not HUNT.
- Destuff: the ones count tracks consecutive emitted 1s. An emitted 0 that follows five 1s is dropped and clears the count.
- Accumulator: kept bits shift into the accumulator LSB-first and bit count increments. At 8 bits the octet becomes pending and bit count returns to 0.
- Pending overwrite: if a pending octet already exists when a new octet completes, the old pending octet is pushed as {0,1,0,0,0000,octet} first.
- FSM states:
  - HUNT: ignore data. Flag -> OPEN.
  - OPEN: idle flags keep the state in OPEN. The first emitted kept bit -> FRAME.
  - FRAME:
    - Closing flag with pending octet and bit count=0 -> push {1,1,0,0,...,octet}.
    - Closing flag with pending octet and bit count!=0 -> push {1,1,0,1,...,octet}; the partial bits are discarded.
    - Closing flag with no pending octet (fewer than 8 bits) -> push {1,0,0,1,...,0x00}.
    - After any closing flag: go to OPEN; accumulator, bit count, ones count and pending are cleared. The flag is shared as the opening flag of the next frame.
  - Abort:
    - In FRAME: push {1,0,1,0,...,0x00}, discard pending and accumulator, go to HUNT.
    - In OPEN or HUNT: go to HUNT with no push.
- enable=0: state=HUNT and mask=0 every cycle; no pushes occur. A word already held stays readable.
- Push timing: the word is in spi_data and spi_data_request=1 on the clk edge after the bit_en cycle that produced it.
- Overrun: a push while spi_data_request=1 drops the new word, keeps the held word unchanged, and sets overrun. overrun clears only on reset.
- Read: on a spi_data_strobe rising edge (strobe=1, previous=0), spi_data_request <= 0 on the next edge; spi_data holds its value.
- Read and push in the same cycle: the push wins; spi_data takes the new word, request stays 1, and no overrun is flagged.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.

Test Plan:
- Flag, 0x41, 0x42, flag (LSB-first, no stuffing) -> words 0x4041 then 0xC042; request drops after each strobe edge.
- Flag, 0xFF, 0x00, flag; the line carries 11111 0 111 for 0xFF -> words 0x40FF, 0xC000; the stuffed 0 is not counted.
- Flag, 0x55, then eight 1s -> 0x4055 is never pushed; word 0xA000 is pushed; state HUNT; a later flag+0x10+flag yields 0xC010.
- Flag, 0x41, 3 bits 101, flag -> word 0xD041; flag, 5 bits, flag -> 0x9000.
- Three-octet frame with no strobes -> first word 0x40xx held; overrun=1 after the second push; the held word is still 0x40xx.
- Assert reset after 12 bits of a frame -> all outputs 0 at once; frame flag+0x7D+flag after release -> 0xC07D.

Source files
------------

// File: rtl/rx_deframer.sv
// Receive-side HDLC deframer: flag hunt, zero destuffing, abort detection and
// LSB-first octet assembly into 16-bit status words behind one holding register.
module rx_deframer (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxdata,
   input  logic        bit_en,
   input  logic        enable,
   output logic [15:0] spi_data,
   output logic        spi_data_request,
   input  logic        spi_data_strobe,
   output logic        overrun,
   output logic        rx_active
);

   // state | meaning
   // HUNT  | searching for a flag, no data emitted
   // OPEN  | flag(s) seen, waiting for the first kept data bit
   // FRAME | assembling octets until a closing flag or an abort

   typedef enum logic [1:0] {HUNT, OPEN, FRAME} state_t;

   state_t      state, nxt_state;
   logic [7:0]  w, nxt_w, mask, nxt_mask, acc, nxt_acc, pend, nxt_pend;
   logic [2:0]  ones_cnt, nxt_ones_cnt, bit_cnt, nxt_bit_cnt;
   logic        pend_v, nxt_pend_v;
   logic        strobe_q, def_v;
   logic [15:0] def_word;
   logic        push_a_v, push_b_v;
   logic [15:0] push_a_word, push_b_word, close_word;
   logic [7:0]  w_new, octet;
   logic        flag_ev, abort_ev, emit, bit_out, kept, in_frame;
   logic        rd, free;

   assign w_new    = {w[6:0], rxdata};
   assign flag_ev  = (w_new == 8'h7E);
   assign abort_ev = (w_new[6:0] == 7'h7F);
   assign emit     = mask[7] && (state != HUNT);
   assign bit_out  = w[7];
   assign octet    = {bit_out, acc[7:1]};
   assign rd       = spi_data_strobe && !strobe_q;
   assign free     = !spi_data_request || rd;

   always_comb begin
      nxt_state    = state;
      nxt_w        = w;
      nxt_mask     = mask;
      nxt_acc      = acc;
      nxt_pend     = pend;
      nxt_pend_v   = pend_v;
      nxt_ones_cnt = ones_cnt;
      nxt_bit_cnt  = bit_cnt;
      push_a_v     = 1'b0;
      push_a_word  = '0;
      push_b_v     = 1'b0;
      push_b_word  = '0;
      close_word   = '0;
      kept         = 1'b0;
      in_frame     = 1'b0;
      if (bit_en) nxt_w = w_new;
      if (!enable) begin
         nxt_state    = HUNT;
         nxt_mask     = '0;
         nxt_acc      = '0;
         nxt_pend_v   = 1'b0;
         nxt_ones_cnt = '0;
         nxt_bit_cnt  = '0;
      end else if (bit_en) begin
         nxt_mask = (flag_ev || abort_ev) ? 8'h00 : {mask[6:0], 1'b1};
         if (emit) begin
            if (!bit_out && ones_cnt == 3'd5) begin
               nxt_ones_cnt = '0;
            end else begin
               kept = 1'b1;
               if (!bit_out)              nxt_ones_cnt = '0;
               else if (ones_cnt != 3'd7) nxt_ones_cnt = ones_cnt + 3'd1;
            end
         end
         if (kept) begin
            nxt_acc   = octet;
            nxt_state = FRAME;
            if (bit_cnt == 3'd7) begin
               nxt_bit_cnt = '0;
               nxt_pend    = octet;
               nxt_pend_v  = 1'b1;
               if (pend_v) begin
                  push_a_v    = 1'b1;
                  push_a_word = {8'h40, pend};
               end
            end else begin
               nxt_bit_cnt = bit_cnt + 3'd1;
            end
         end
         in_frame = (state == FRAME) || kept;
         // The last data bit leaves the window in the same cycle the closing
         // flag completes, so the close word is built from the updated values.
         if (nxt_pend_v)
            close_word = {(nxt_bit_cnt == 3'd0) ? 8'hC0 : 8'hD0, nxt_pend};
         else
            close_word = 16'h9000;
         if (abort_ev || flag_ev) begin
            if (abort_ev) begin
               push_a_v    = in_frame;
               push_a_word = 16'hA000;
               nxt_state   = HUNT;
            end else begin
               if (in_frame) begin
                  if (push_a_v) begin
                     push_b_v    = 1'b1;
                     push_b_word = close_word;
                  end else begin
                     push_a_v    = 1'b1;
                     push_a_word = close_word;
                  end
               end
               nxt_state = OPEN;
            end
            nxt_acc      = '0;
            nxt_bit_cnt  = '0;
            nxt_ones_cnt = '0;
            nxt_pend_v   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= HUNT;
         w                <= '0;
         mask             <= '0;
         acc              <= '0;
         pend             <= '0;
         pend_v           <= 1'b0;
         ones_cnt         <= '0;
         bit_cnt          <= '0;
         strobe_q         <= 1'b0;
         def_v            <= 1'b0;
         def_word         <= '0;
         spi_data         <= '0;
         spi_data_request <= 1'b0;
         overrun          <= 1'b0;
         rx_active        <= 1'b0;
      end else begin
         state     <= nxt_state;
         w         <= nxt_w;
         mask      <= nxt_mask;
         acc       <= nxt_acc;
         pend      <= nxt_pend;
         pend_v    <= nxt_pend_v;
         ones_cnt  <= nxt_ones_cnt;
         bit_cnt   <= nxt_bit_cnt;
         strobe_q  <= spi_data_strobe;
         rx_active <= (nxt_state == FRAME);
         // A close word that coincides with an octet push waits in def_word
         // until the holding register is free.
         if (def_v && free) begin
            spi_data         <= def_word;
            spi_data_request <= 1'b1;
            def_v            <= 1'b0;
            if (push_a_v) overrun <= 1'b1;
         end else if (push_a_v) begin
            if (free) begin
               spi_data         <= push_a_word;
               spi_data_request <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd) begin
            spi_data_request <= 1'b0;
         end
         if (push_b_v) begin
            if (def_v && !free) begin
               overrun <= 1'b1;
            end else begin
               def_v    <= 1'b1;
               def_word <= push_b_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: a stuffing transmitter drives frames, and expected
// words are derived from frame contents alone.
module tb_rx_deframer;

   logic        clk = 1'b0;
   logic        reset;
   logic        rxdata;
   logic        bit_en;
   logic        enable;
   logic [15:0] spi_data;
   logic        spi_data_request;
   logic        spi_data_strobe;
   logic        overrun;
   logic        rx_active;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ones_tx = 0;
   bit          consume_en = 1'b1;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [7:0]  frm[$];

   rx_deframer dut (
      .clk              (clk),
      .reset            (reset),
      .rxdata           (rxdata),
      .bit_en           (bit_en),
      .enable           (enable),
      .spi_data         (spi_data),
      .spi_data_request (spi_data_request),
      .spi_data_strobe  (spi_data_strobe),
      .overrun          (overrun),
      .rx_active        (rx_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      int gap;
      @(negedge clk);
      rxdata = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_dbit(input logic b);
      send_bit(b);
      if (b) begin
         ones_tx++;
         if (ones_tx == 5) begin
            send_bit(1'b0);
            ones_tx = 0;
         end
      end else begin
         ones_tx = 0;
      end
   endtask

   task automatic send_octet(input logic [7:0] o);
      for (int i = 0; i < 8; i++) send_dbit(o[i]);
   endtask

   task automatic send_flag();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) send_bit(f[i]);
      ones_tx = 0;
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   // Closed frame: every octet but the last is plain data; the last carries eop
   // and a residue flag when trailing bits follow it.
   task automatic model_frame(input int k);
      int n;
      n = frm.size();
      for (int i = 0; i < n - 1; i++) exp_q.push_back({8'h40, frm[i]});
      if (n > 0)      exp_q.push_back({(k == 0) ? 8'hC0 : 8'hD0, frm[n-1]});
      else if (k > 0) exp_q.push_back(16'h9000);
   endtask

   // Aborted frame: the last octet never completes and the one before it is
   // still pending, so only earlier octets reach the consumer.
   task automatic model_abort();
      int n;
      n = frm.size();
      for (int i = 0; i < n - 2; i++) exp_q.push_back({8'h40, frm[i]});
      exp_q.push_back(16'hA000);
   endtask

   task automatic compare_words(input string tag);
      int m;
      repeat (40) @(negedge clk);
      check({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) check(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      spi_data_strobe = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_data_strobe) begin
            spi_data_strobe = 1'b0;
         end else if (spi_data_request && consume_en) begin
            got_q.push_back(spi_data);
            spi_data_strobe = 1'b1;
         end
      end
   end

   initial begin
      logic [7:0] o0, o1, o2;
      int         n, k;
      reset  = 1'b1;
      rxdata = 1'b0;
      bit_en = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", spi_data, 16'h0000);
      check("rst_req", {15'd0, spi_data_request}, 16'd0);
      check("rst_ovr", {15'd0, overrun}, 16'd0);
      check("rst_act", {15'd0, rx_active}, 16'd0);
      reset = 1'b0;

      send_flag(); send_octet(8'h41); send_octet(8'h42); send_flag();
      exp_q.push_back(16'h4041); exp_q.push_back(16'hC042);
      compare_words("two_octets");

      send_flag(); send_octet(8'hFF); send_octet(8'h00); send_flag();
      exp_q.push_back(16'h40FF); exp_q.push_back(16'hC000);
      compare_words("stuffed");

      send_flag(); send_octet(8'h55); send_ones(8);
      exp_q.push_back(16'hA000);
      compare_words("abort");
      check("abort_act", {15'd0, rx_active}, 16'd0);
      send_flag(); send_octet(8'h10); send_flag();
      exp_q.push_back(16'hC010);
      compare_words("after_abort");

      send_flag(); send_octet(8'h41); send_dbit(1'b1); send_dbit(1'b0); send_dbit(1'b1); send_flag();
      exp_q.push_back(16'hD041);
      send_flag();
      for (int i = 0; i < 5; i++) send_dbit(i[0]);
      send_flag();
      exp_q.push_back(16'h9000);
      compare_words("residue");

      for (int it = 0; it < 24; it++) begin
         frm.delete();
         send_flag();
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            frm[n-1][7] = 1'b0;
            for (int i = 0; i < n; i++) send_octet(frm[i]);
            send_ones(8);
            model_abort();
            compare_words("rand_abort");
         end else begin
            n = $urandom_range(0, 4);
            k = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < n; i++) send_octet(frm[i]);
            for (int i = 0; i < k; i++) send_dbit(1'($urandom_range(0, 1)));
            send_flag();
            model_frame(k);
            compare_words("rand_frame");
         end
      end
      check("rand_ovr", {15'd0, overrun}, 16'd0);

      enable = 1'b0;
      send_flag(); send_octet(8'h33); send_flag();
      compare_words("disabled");
      check("dis_act", {15'd0, rx_active}, 16'd0);
      enable = 1'b1;

      consume_en = 1'b0;
      o0 = 8'($urandom_range(0, 255));
      o1 = 8'($urandom_range(0, 255));
      o2 = 8'($urandom_range(0, 255));
      send_flag(); send_octet(o0); send_octet(o1); send_octet(o2);
      repeat (2) @(negedge clk);
      check("ovr_req", {15'd0, spi_data_request}, 16'd1);
      check("ovr_before", {15'd0, overrun}, 16'd0);
      check("ovr_held1", spi_data, {8'h40, o0});
      send_flag();
      repeat (3) @(negedge clk);
      check("ovr_set", {15'd0, overrun}, 16'd1);
      check("ovr_held2", spi_data, {8'h40, o0});
      #2 reset = 1'b1;
      #1;
      check("ovr_rst_data", spi_data, 16'h0000);
      check("ovr_rst_ovr", {15'd0, overrun}, 16'd0);
      @(negedge clk) reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      consume_en = 1'b1;

      send_flag();
      for (int i = 0; i < 12; i++) send_dbit(1'($urandom_range(0, 1)));
      check("mid_act", {15'd0, rx_active}, 16'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_data", spi_data, 16'h0000);
      check("mid_rst_req", {15'd0, spi_data_request}, 16'd0);
      check("mid_rst_ovr", {15'd0, overrun}, 16'd0);
      check("mid_rst_act", {15'd0, rx_active}, 16'd0);
      @(negedge clk) reset = 1'b0;
      send_flag(); send_octet(8'h7D); send_flag();
      exp_q.push_back(16'hC07D);
      compare_words("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
